// File: rtl/issue_queue_nw.sv
// issue_queue_nw: circular instruction buffer between decode and execute.
// WR_LANES compacted write lanes, one combinational read port, a registered
// occupancy count and a per-lane source-register hazard scoreboard.
// Optional build macro: ISSUE_QUEUE_BYPASS_EN (empty-queue fall-through of
// lane 0 to the read port).
module issue_queue_nw #(
    parameter int DATA_WIDTH = 92,
    parameter int DEPTH      = 8,
    parameter int WR_LANES   = 2,
    parameter int HZ_LANES   = 2,
    parameter int RD_LSB     = 86
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic                           flush,
    input  logic [WR_LANES-1:0]            wr_valid,
    input  logic [WR_LANES*DATA_WIDTH-1:0] wr_data,
    output logic [WR_LANES-1:0]            wr_ready,
    input  logic                           rd_en,
    output logic                           rd_valid,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]         count,
    input  logic [HZ_LANES*12-1:0]         hz_rs,
    output logic [HZ_LANES-1:0]            hz_hit
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Pointers carry one extra wrap bit above the slot index.
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [WR_LANES-1:0]   lane_acc;
    logic [WR_LANES-1:0]   lane_store;
    logic [IDX_W-1:0]      lane_slot [WR_LANES];
    logic [PTR_W-1:0]      n_store;
    logic                  empty;
    logic                  pop;
    logic                  bypass_take;
    logic [IDX_W-1:0]      rd_idx;

    genvar gi;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign pop    = rd_en & ~empty;
    assign rd_idx = rd_ptr_q[IDX_W-1:0];
    assign count  = count_q;

    // Lane i may push only if at least i+1 slots were free at the start of
    // the cycle; a same-cycle pop never frees a slot early.
    generate
        for (gi = 0; gi < WR_LANES; gi++) begin : g_lane
            assign wr_ready[gi] = (DEPTH - int'(count_q)) > gi;
            assign lane_acc[gi] = wr_valid[gi] & wr_ready[gi];
        end
    endgenerate

`ifdef ISSUE_QUEUE_BYPASS_EN
    logic bypass_show;

    // Lane 0 falls through only when nothing is queued ahead of it.
    assign bypass_show = empty & rstN & ~flush & wr_valid[0];
    assign bypass_take = bypass_show & rd_en;

    // Read port: stored head entry, else lane 0 falling through an empty queue
    always_comb begin
        rd_valid = 1'b0;
        rd_data  = '0;
        if (!empty) begin
            rd_valid = 1'b1;
            rd_data  = mem_q[rd_idx];
        end else if (bypass_show) begin
            rd_valid = 1'b1;
            rd_data  = wr_data[DATA_WIDTH-1:0];
        end
    end
`else
    assign bypass_take = 1'b0;

    // Read port: stored head entry, zero when nothing is queued
    always_comb begin
        rd_valid = ~empty;
        rd_data  = '0;
        if (!empty) begin
            rd_data = mem_q[rd_idx];
        end
    end
`endif

    // Compact accepted lanes onto consecutive slots from wr_ptr; a lane 0
    // consumed by fall-through takes no slot.
    always_comb begin
        n_store    = '0;
        lane_store = '0;
        for (int i = 0; i < WR_LANES; i++) begin
            lane_slot[i] = wr_ptr_q[IDX_W-1:0];
            if (lane_acc[i] && !(i == 0 && bypass_take)) begin
                lane_slot[i]  = IDX_W'(wr_ptr_q + n_store);
                lane_store[i] = 1'b1;
                n_store       = n_store + PTR_W'(1);
            end
        end
    end

    // Next pointers, occupancy and valid bits; flush discards everything
    always_comb begin
        wr_ptr_d = wr_ptr_q + n_store;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + n_store - PTR_W'(pop);
        valid_d  = valid_q;
        if (pop) begin
            valid_d[rd_idx] = 1'b0;
        end
        for (int i = 0; i < WR_LANES; i++) begin
            if (lane_store[i]) begin
                valid_d[lane_slot[i]] = 1'b1;
            end
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = '0;
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Packet storage; stale data in freed slots is masked by the valid bits
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_LANES; i++) begin
            if (lane_store[i]) begin
                mem_q[lane_slot[i]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Hazard scoreboard: each lane checks two sources against live Rd fields
    generate
        for (gi = 0; gi < HZ_LANES; gi++) begin : g_hz
            logic [5:0] rs_a;
            logic [5:0] rs_b;
            logic       hit_a;
            logic       hit_b;

            assign rs_a = hz_rs[gi*12 +: 6];
            assign rs_b = hz_rs[gi*12+6 +: 6];

            // Compare both sources against the Rd of every valid entry
            always_comb begin
                hit_a = 1'b0;
                hit_b = 1'b0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (valid_q[k] && (mem_q[k][RD_LSB +: 6] == rs_a)) begin
                        hit_a = 1'b1;
                    end
                    if (valid_q[k] && (mem_q[k][RD_LSB +: 6] == rs_b)) begin
                        hit_b = 1'b1;
                    end
                end
            end

            // Register 0 is never a hazard.
            assign hz_hit[gi] = (hit_a && (rs_a != 6'd0)) || (hit_b && (rs_b != 6'd0));
        end
    endgenerate

endmodule

// File: tb/tb_issue_queue_nw.sv
// Bench for issue_queue_nw: hand-computed vector table, corner-case
// sequences and randomized traffic checked against a queue-based model.
module tb_issue_queue_nw;
    localparam int DW    = 92;
    localparam int DEPTH = 8;
    localparam int WL    = 2;
    localparam int HL    = 2;
    localparam int RDL   = 86;

    logic            clk = 1'b0;
    logic            rstN;
    logic            flush;
    logic [WL-1:0]   wr_valid;
    logic [WL*DW-1:0] wr_data;
    logic [WL-1:0]   wr_ready;
    logic            rd_en;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic [3:0]      count;
    logic [HL*12-1:0] hz_rs;
    logic [HL-1:0]   hz_hit;

    issue_queue_nw #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .WR_LANES(WL), .HZ_LANES(HL), .RD_LSB(RDL)
    ) dut (
        .clk(clk), .rstN(rstN), .flush(flush),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .hz_rs(hz_rs), .hz_hit(hz_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rn;
        bit        fl;
        bit [1:0]  wv;
        bit        re;
        bit [5:0]  r0;
        bit [5:0]  r1;
        bit [23:0] hz;
        bit        chk_hit;
        bit [1:0]  hit;
        bit [3:0]  cnt;
        bit        rv;
        bit [1:0]  rdy;
    } vec_t;

    vec_t        vt[$];
    logic [DW-1:0] mq[$];
    bit          known = 1'b0;
    int unsigned tag = 1;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [DW-1:0] mk(logic [5:0] rd, int unsigned t);
        return {rd, 54'd0, t};
    endfunction

    task automatic cmp(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(bit rn, bit fl, bit [1:0] wv, bit re, bit [5:0] r0, bit [5:0] r1,
                       bit [23:0] hz, bit ch, bit [1:0] hit, bit [3:0] cnt, bit rv, bit [1:0] rdy);
        vec_t v;
        v.rn = rn; v.fl = fl; v.wv = wv; v.re = re; v.r0 = r0; v.r1 = r1; v.hz = hz;
        v.chk_hit = ch; v.hit = hit; v.cnt = cnt; v.rv = rv; v.rdy = rdy;
        vt.push_back(v);
    endtask

    task automatic drive(bit rn, bit fl, bit [1:0] wv, bit re, bit [5:0] r0, bit [5:0] r1,
                         bit [23:0] hz);
        assert (wv != 2'b10) else $error("non-contiguous wr_valid driven");
        rstN     = rn;
        flush    = fl;
        wr_valid = wv;
        rd_en    = re;
        hz_rs    = hz;
        wr_data  = {mk(r1, tag + 1), mk(r0, tag)};
        tag      = tag + 2;
    endtask

    function automatic bit bypass_now();
`ifdef ISSUE_QUEUE_BYPASS_EN
        return (mq.size() == 0) && rstN && !flush && wr_valid[0];
`else
        return 1'b0;
`endif
    endfunction

    // Compare every output against the model for the current (pre-edge) state.
    task automatic check_cycle();
        int          sz;
        logic [1:0]  e_rdy;
        logic        e_rv;
        logic [DW-1:0] e_rd;
        logic [1:0]  e_hit;
        logic [5:0]  src;
        if (!known) return;
        sz = mq.size();
        for (int i = 0; i < WL; i++) e_rdy[i] = (DEPTH - sz) > i;
        e_rv = (sz > 0);
        e_rd = (sz > 0) ? mq[0] : '0;
        if (sz == 0 && bypass_now()) begin
            e_rv = 1'b1;
            e_rd = wr_data[DW-1:0];
        end
        e_hit = '0;
        for (int j = 0; j < HL; j++) begin
            for (int s = 0; s < 2; s++) begin
                src = hz_rs[j*12 + s*6 +: 6];
                foreach (mq[k]) if (src != 0 && mq[k][RDL +: 6] == src) e_hit[j] = 1'b1;
            end
        end
        cmp("count", count, sz);
        cmp("wr_ready", wr_ready, e_rdy);
        cmp("rd_valid", rd_valid, e_rv);
        cmp("rd_data", rd_data, e_rd);
        cmp("hz_hit", hz_hit, e_hit);
    endtask

    // Apply the clock-edge effect of the current inputs to the model queue.
    task automatic model_edge();
        int sz;
        int nacc;
        bit byp;
        if (!rstN || flush) begin
            mq.delete();
            known = 1'b1;
            return;
        end
        sz   = mq.size();
        nacc = 0;
        for (int i = 0; i < WL; i++) if (wr_valid[i] && (DEPTH - sz) > i) nacc++;
        byp = bypass_now() && rd_en;
        if (rd_en && sz > 0) void'(mq.pop_front());
        for (int i = 0; i < nacc; i++) begin
            if (!(i == 0 && byp)) mq.push_back(wr_data[i*DW +: DW]);
        end
    endtask

    task automatic step();
        #3;
        check_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        // Hand-computed table for DEPTH=8, WR_LANES=2.
        add(0,0,3,0,0,0,0, 0,0, 0,0,3);                  // reset with pushes
        add(0,0,3,0,0,0,0, 0,0, 0,0,3);
        for (int k = 1; k <= 4; k++)                     // fill 2 per cycle
            add(1,0,3,0,0,0,0, 0,0, 4'(2*k),1,(k == 4) ? 2'b00 : 2'b11);
        add(1,0,3,0,0,0,0, 0,0, 8,1,0);                  // push when full dropped
        for (int k = 7; k >= 0; k--)                     // drain in order
            add(1,0,0,1,0,0,0, 0,0, 4'(k),k > 0,(k == 7) ? 2'b01 : 2'b11);
        add(1,0,0,1,0,0,0, 0,0, 0,0,3);                  // pop while empty ignored
        for (int k = 1; k <= 3; k++) add(1,0,3,0,0,0,0, 0,0, 4'(2*k),1,3);
        add(1,0,1,0,0,0,0, 0,0, 7,1,1);                  // count 7
        add(1,0,3,0,0,0,0, 0,0, 8,1,0);                  // only lane 0 fits
        for (int k = 7; k >= 4; k--) add(1,0,0,1,0,0,0, 0,0, 4'(k),1,(k == 7) ? 2'b01 : 2'b11);
        add(1,0,3,1,0,0,0, 0,0, 5,1,3);                  // push 2 pop 1 at count 4
        add(1,1,0,0,0,0,0, 0,0, 0,0,3);                  // flush
        for (int k = 1; k <= 3; k++) add(1,0,3,0,0,0,0, 0,0, 4'(2*k),1,3);
        add(1,0,1,0,0,0,0, 0,0, 7,1,1);                  // wr_ptr = 7
        for (int k = 6; k >= 1; k--) add(1,0,0,1,0,0,0, 0,0, 4'(k),1,3); // rd_ptr = 6
        add(1,0,3,0,0,0,0, 0,0, 3,1,3);                  // straddles the wrap
        for (int k = 2; k >= 0; k--) add(1,0,0,1,0,0,0, 0,0, 4'(k),k > 0,3);
        add(1,1,0,0,0,0,0, 0,0, 0,0,3);
        add(1,0,3,0,5,0,0, 0,0, 2,1,3);                  // Rd=5 then Rd=0
        add(1,0,0,1,0,0,24'h0C0005, 1,2'b01, 1,1,3);     // popped entry still hits
        add(1,0,0,0,0,0,24'h0C0005, 1,2'b00, 1,1,3);     // Rd=5 gone
        add(1,1,3,0,0,0,0, 0,0, 0,0,3);                  // flush beats push

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rn, vt[i].fl, vt[i].wv, vt[i].re, vt[i].r0, vt[i].r1, vt[i].hz);
            #3;
            check_cycle();
            if (vt[i].chk_hit) cmp($sformatf("tbl%0d_hz_hit", i), hz_hit, vt[i].hit);
            @(posedge clk);
            model_edge();
            #1;
            cmp($sformatf("tbl%0d_count", i), count, vt[i].cnt);
            cmp($sformatf("tbl%0d_rd_valid", i), rd_valid, vt[i].rv);
            cmp($sformatf("tbl%0d_wr_ready", i), wr_ready, vt[i].rdy);
            $display("vec %0d: count=%0d rd_valid=%0b wr_ready=%b hz_hit=%b", i, count, rd_valid, wr_ready, hz_hit);
        end

        // Reset mid-operation overrides flush, pushes and pops.
        drive(1,0,3,0,1,2,0); step();
        drive(1,0,3,0,3,4,0); step();
        drive(0,1,3,1,0,0,0); step();
        cmp("midrst_count", count, 0);
        cmp("midrst_rd_valid", rd_valid, 0);
        $display("midreset: count=%0d rd_valid=%0b", count, rd_valid);
        drive(1,0,0,0,0,0,0); step();

`ifdef ISSUE_QUEUE_BYPASS_EN
        // Fall-through: lane 0 consumed in the same cycle, nothing stored.
        drive(1,0,1,1,7,0,24'h000007);
        #3;
        cmp("byp_rd_valid", rd_valid, 1);
        cmp("byp_rd_data", rd_data, mk(6'd7, tag - 2));
        cmp("byp_hz_hit", hz_hit, 0);
        check_cycle();
        @(posedge clk);
        model_edge();
        #1;
        cmp("byp_count", count, 0);
        $display("bypass: count=%0d", count);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            int  n;
            bit  re;
            bit [23:0] hz;
            n  = $urandom_range(0, 2);
            re = ($urandom_range(0, 9) < (((c / 100) % 2) ? 7 : 3));
            for (int b = 0; b < 4; b++) hz[b*6 +: 6] = 6'($urandom_range(0, 7));
            drive($urandom_range(0, 149) != 0, $urandom_range(0, 59) == 0, 2'((1 << n) - 1), re,
                  6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), hz);
            step();
            $display("rand %0d: count=%0d model=%0d", c, count, mq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
